vga_plot_arbiter: RTL and testbench

Shares the single VGA framebuffer write port (x, y, colour, plot into vga_adapter, 160x120, 3-bit colour) between several pixel producers: player sprite, trail painter, obstacle redraw. It uses round-robin arbitration with an optional per-requester lock, so a multi-pixel sprite is written atomically. Off-screen pixels are clipped. It sits inside system, between the drawing FSMs and the adapter port.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_plot_arbiter_if.sv | 38 +++
 rtl/rr_pick.sv | 47 ++++
 rtl/vga_plot_arbiter.sv | 147 ++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 160x120, 3-bit-colour VGA framebuffer path and the
// state encoding of the plot arbiter.
//   SCREEN_W / SCREEN_H : visible framebuffer size
//   X_W / Y_W / COLOR_W : pixel coordinate and colour widths at the adapter
//   BLACK .. WHITE      : 3-bit RGB colour constants
//   arb_state_t         : arbiter state (IDLE = free arbitration, LOCKED =
//                         grant pinned to one requester)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;

    localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] RED     = 3'b100;
    localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter_if
// Bundle of the pixel-producer request bus shared by NUM_REQ drawing FSMs.
//   req_valid [NUM_REQ]        : requester i has a pixel pending
//   req_lock  [NUM_REQ]        : requester i wants to keep the grant
//   req_x     [NUM_REQ*X_W]    : packed x, requester i at [X_W*i +: X_W]
//   req_y     [NUM_REQ*Y_W]    : packed y, requester i at [Y_W*i +: Y_W]
//   req_color [NUM_REQ*COLOR_W]: packed colour
//   req_ready [NUM_REQ]        : one-hot or zero, driven by the arbiter
// Handshake: a pixel moves on a rising clock edge where req_valid[i] and
// req_ready[i] are both high. A requester holds valid and its data stable
// until that edge; ready may depend combinationally on valid.
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vga_plot_arbiter_if
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 3
) ();

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_lock;
    logic [NUM_REQ*X_W-1:0]     req_x;
    logic [NUM_REQ*Y_W-1:0]     req_y;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [NUM_REQ-1:0]         req_ready;

    modport master (
        output req_valid, req_lock, req_x, req_y, req_color,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_x, req_y, req_color,
        output req_ready
    );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: the first set bit of valid, searching
// ptr, ptr+1, ... with wrap at NUM_REQ (explicit wrap, so NUM_REQ need not
// be a power of two).
//   valid [NUM_REQ] : request vector
//   ptr   [IDX_W]   : highest-priority index this cycle (must be < NUM_REQ)
//   grant [NUM_REQ] : one-hot winner, zero when nothing is valid
//   idx   [IDX_W]   : winner index, 0 when nothing is valid
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

    always_comb begin
        logic           found;
        logic [IDX_W:0] cand_w;
        logic [IDX_W-1:0] cand;
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        cand_w = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so ptr+k cannot overflow before the wrap.
            cand_w = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand_w >= N_W) begin
                cand_w = cand_w - N_W;
            end
            cand = cand_w[IDX_W-1:0];
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter
// Shares the single framebuffer write port between NUM_REQ pixel producers.
// Round-robin arbitration; a requester may lock the grant to write a
// multi-pixel sprite atomically (forced release after LOCK_MAX cycles).
// Off-screen pixels are accepted but not plotted, and counted.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : request bus (slave side), req_ready combinational
//   x, y, color : registered pixel to the adapter, held while plot=0
//   plot        : registered one-cycle write strobe per on-screen pixel
//   grant_id    : index of the last requester that transferred
//   clip_count  : clipped-pixel count, saturating at 255
//   state       : arbiter FSM state (debug)
//   rr_ptr      : round-robin priority pointer (debug)
// ---------------------------------------------------------------------------
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int WIDTH    = SCREEN_W,
    parameter int HEIGHT   = SCREEN_H,
    parameter int LOCK_MAX = 64,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(LOCK_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    vga_plot_arbiter_if.slave  bus,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic [IDX_W-1:0]   grant_id,
    output logic [7:0]         clip_count,
    output arb_state_t         state,
    output logic [IDX_W-1:0]   rr_ptr
);

    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   lock_cnt;

    logic [X_W-1:0]     px [NUM_REQ];
    logic [Y_W-1:0]     py [NUM_REQ];
    logic [COLOR_W-1:0] pc [NUM_REQ];

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] ready;
    logic [IDX_W-1:0]   sel;
    logic               xfer;
    logic               in_range;
    logic               release_lock;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            px[i] = bus.req_x[i*X_W +: X_W];
            py[i] = bus.req_y[i*Y_W +: Y_W];
            pc[i] = bus.req_color[i*COLOR_W +: COLOR_W];
        end
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // While locked only the owner can be ready, even if it is idle.
    always_comb begin
        ready = '0;
        sel   = pick_idx;
        if (state == LOCKED) begin
            sel        = owner;
            ready[owner] = bus.req_valid[owner];
        end else begin
            ready = pick_grant;
        end
        if (reset) begin
            ready = '0;
        end
    end

    assign bus.req_ready = ready;
    assign xfer          = |(bus.req_valid & ready);
    assign in_range      = ({1'b0, px[sel]} < (X_W+1)'(WIDTH)) &&
                           ({1'b0, py[sel]} < (Y_W+1)'(HEIGHT));
    assign release_lock  = !bus.req_lock[owner] ||
                           (lock_cnt == CNT_W'(LOCK_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            color      <= '0;
            plot       <= 1'b0;
            grant_id   <= '0;
            clip_count <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            lock_cnt   <= '0;
            state      <= IDLE;
        end else begin
            plot <= 1'b0;
            if (xfer) begin
                grant_id <= sel;
                if (in_range) begin
                    x     <= px[sel];
                    y     <= py[sel];
                    color <= pc[sel];
                    plot  <= 1'b1;
                end else if (clip_count != 8'hFF) begin
                    clip_count <= clip_count + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (bus.req_lock[sel]) begin
                            state    <= LOCKED;
                            owner    <= sel;
                            lock_cnt <= '0;
                        end else begin
                            rr_ptr <= rr_next(sel);
                        end
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    // The owner's transfer this cycle completes; the others
                    // compete again only from the next cycle.
                    if (release_lock) begin
                        state  <= IDLE;
                        rr_ptr <= rr_next(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_arbiter
// Bench for vga_plot_arbiter with NUM_REQ=3 and LOCK_MAX=4. Each step drives
// the request bus, checks req_ready against the expected grant, pushes the
// expected registered outputs to exp_q and pops/compares them after the edge.
// ---------------------------------------------------------------------------
module tb_vga_plot_arbiter;
    import vga_pkg::*;

    localparam int W = 1 + 8 + 7 + 3 + 2 + 8;

    logic clk;
    logic reset;

    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic [1:0] grant_id;
    logic [7:0] clip_count;
    arb_state_t state;
    logic [1:0] rr_ptr;

    vga_plot_arbiter_if #(.NUM_REQ(3)) bus ();

    vga_plot_arbiter #(.NUM_REQ(3), .LOCK_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .grant_id   (grant_id),
        .clip_count (clip_count),
        .state      (state),
        .rr_ptr     (rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // stimulus state
    logic [2:0] valid;
    logic [2:0] lock;
    logic [7:0] px [3];
    logic [6:0] py [3];
    logic [2:0] pc [3];

    // reference model of registered outputs
    logic       m_plot;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic [1:0] m_gid;
    logic [7:0] m_clip;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    task automatic apply();
        bus.req_valid = valid;
        bus.req_lock  = lock;
        for (int i = 0; i < 3; i++) begin
            bus.req_x[i*8 +: 8]     = px[i];
            bus.req_y[i*7 +: 7]     = py[i];
            bus.req_color[i*3 +: 3] = pc[i];
        end
    endtask

    task automatic model_reset();
        m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0; m_gid = '0; m_clip = '0;
        exp_q.delete();
    endtask

    // One clock of traffic: exp_ready is the grant the arbiter must give.
    task automatic step(input string tag, input logic [2:0] exp_ready);
        logic [2:0]   xfer;
        int           w;
        logic [W-1:0] e;
        logic [W-1:0] a;
        apply();
        #1;
        checks++;
        if (bus.req_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s ready: got %b expected %b", tag, bus.req_ready, exp_ready);
        end
        xfer   = valid & exp_ready;
        m_plot = 1'b0;
        if (xfer != 3'b000) begin
            w     = xfer[0] ? 0 : (xfer[1] ? 1 : 2);
            m_gid = 2'(w);
            if (px[w] < 8'd160 && py[w] < 7'd120) begin
                m_x = px[w]; m_y = py[w]; m_c = pc[w]; m_plot = 1'b1;
            end else if (m_clip != 8'd255) begin
                m_clip = m_clip + 8'd1;
            end
        end
        exp_q.push_back({m_plot, m_x, m_y, m_c, m_gid, m_clip});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = {plot, x, y, color, grant_id, clip_count};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s out{plot,x,y,c,gid,clip}: got %h expected %h", tag, a, e);
        end
    endtask

    task automatic rand_pixels();
        for (int i = 0; i < 3; i++) begin
            px[i] = 8'($urandom_range(0, 159));
            py[i] = 7'($urandom_range(0, 119));
            pc[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 3'b111;
        lock  = 3'b000;
        rand_pixels();
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 3'b000) begin
            errors++; $display("FAIL reset ready: got %b expected 000", bus.req_ready);
        end
        checks++;
        if ({plot, x, y, clip_count} !== 24'd0) begin
            errors++; $display("FAIL reset outs: got %h expected 0", {plot, x, y, clip_count});
        end
        checks++;
        if (state !== IDLE || rr_ptr !== 2'd0) begin
            errors++; $display("FAIL reset state: got %0d/%0d expected 0/0", state, rr_ptr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 3'b001) begin
            errors++; $display("FAIL reset first_grant: got %b expected 001", bus.req_ready);
        end
        valid = 3'b000;
        step("reset idle", 3'b000);
    endtask

    task automatic test_round_robin();
        valid = 3'b111;
        lock  = 3'b000;
        for (int k = 0; k < 6; k++) begin
            rand_pixels();
            step("rr", 3'(1 << (k % 3)));
        end
        valid = 3'b000;
        step("rr idle", 3'b000);
    endtask

    task automatic test_lock();
        // Move the pointer to 1 so requester 1 wins next.
        rand_pixels();
        valid = 3'b001;
        lock  = 3'b000;
        step("lock pre", 3'b001);
        valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            px[1] = 8'(10 + k);
            py[1] = 7'd5;
            pc[1] = RED;
            lock  = (k == 3) ? 3'b000 : 3'b010;
            step("lock hold", 3'b010);
        end
        lock = 3'b000;
        step("lock after2", 3'b100);
        step("lock after0", 3'b001);
        valid = 3'b000;
        step("lock idle", 3'b000);
    endtask

    task automatic test_forced_release();
        rand_pixels();
        lock  = 3'b001;
        valid = 3'b001;
        step("force entry", 3'b001);
        valid = 3'b111;
        step("force c0", 3'b001);
        valid = 3'b110;
        step("force owner_idle", 3'b000);
        valid = 3'b111;
        step("force c2", 3'b001);
        step("force c3", 3'b001);
        step("force next", 3'b010);
        valid = 3'b000;
        lock  = 3'b000;
        step("force idle", 3'b000);
    endtask

    task automatic test_clip();
        valid = 3'b100;
        lock  = 3'b000;
        pc[2] = WHITE;
        px[2] = 8'd160; py[2] = 7'd0;
        step("clip x", 3'b100);
        px[2] = 8'd0;   py[2] = 7'd120;
        step("clip y", 3'b100);
        px[2] = 8'd159; py[2] = 7'd119;
        step("clip corner", 3'b100);
        checks++;
        if (clip_count !== 8'd2 || x !== 8'd159 || y !== 7'd119) begin
            errors++;
            $display("FAIL clip totals: got %0d,%0d,%0d expected 2,159,119", clip_count, x, y);
        end
        valid = 3'b000;
        step("clip idle", 3'b000);
    endtask

    task automatic test_reset_mid_lock();
        rand_pixels();
        valid = 3'b001;
        lock  = 3'b001;
        step("midlock entry", 3'b001);
        reset = 1'b1;
        #1;
        checks++;
        if (plot !== 1'b0 || state !== IDLE || rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL midlock reset: got %b/%0d/%0d expected 0/0/0", plot, state, rr_ptr);
        end
        valid = 3'b000;
        lock  = 3'b000;
        model_reset();
        reset = 1'b0;
        valid = 3'b010;
        px[1] = 8'd200;
        py[1] = 7'd3;
        for (int k = 0; k < 300; k++) begin
            step("saturate", 3'b010);
        end
        checks++;
        if (clip_count !== 8'd255) begin
            errors++; $display("FAIL saturate: got %0d expected 255", clip_count);
        end
        valid = 3'b000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_lock();
        test_forced_release();
        test_clip();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
